// File: rtl/fir_coef_loader_if.sv
// Coefficient stream between the host/config side and the FIR coefficient loader.
// The master presents s_valid/s_data and the slave answers with s_ready.
interface fir_coef_loader_if #(
  parameter int DATA_W = 19
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/fir_coef_loader.sv
// FIR distributed-arithmetic LUT coefficient loader.
// Waits for the filter datapath to go quiet, then streams coefficient words
// into the LUT write port (CIN/CADDR/CLOAD) one cycle after each handshake.
// While the load runs, the filter input is held off. When the load ends,
// the loader reports done, error and a running checksum to the host.
module fir_coef_loader #(
  parameter int DATA_W        = 19,
  parameter int ADDR_W        = 11,
  parameter int DEPTH         = 2048,
  parameter int QUIET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   num_words,
  fir_coef_loader_if.slave  s_if,
  input  logic              filter_busy,
  output logic [DATA_W-1:0] CIN,
  output logic [ADDR_W-1:0] CADDR,
  output logic              CLOAD,
  output logic              hold_filter,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [23:0]       checksum
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [ADDR_W:0] DEPTH_L     = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L       = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] ZERO_L      = (ADDR_W + 1)'(0);
  localparam logic [QW-1:0]   QUIET_LAST  = QW'(QUIET_CYCLES - 1);
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_Q = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t          state_r, state_next_s;
  logic [QW-1:0]   quiet_r, quiet_next_s;
  logic [SW-1:0]   settle_r, settle_next_s;
  logic [ADDR_W:0] num_r;
  logic [ADDR_W:0] cnt_r;
  logic            s_ready_s;
  logic            hs_s;
  logic            last_word_s;
  logic            start_legal_s;
  logic            start_ok_s;
  logic            start_bad_s;
  logic            abort_s;

  // The ready signal is gated by abort, so a word offered in the abort cycle is never written.
  assign s_ready_s     = (state_r == ST_LOAD) && !abort;
  assign s_if.s_ready  = s_ready_s;
  assign hs_s          = s_if.s_valid && s_ready_s;
  assign last_word_s   = (cnt_r == (num_r - ONE_L));
  assign start_legal_s = (num_words != ZERO_L) && (num_words <= DEPTH_L);

  // Next-state and per-cycle control decode.
  always_comb begin
    state_next_s  = state_r;
    quiet_next_s  = quiet_r;
    settle_next_s = settle_r;
    start_ok_s    = 1'b0;
    start_bad_s   = 1'b0;
    abort_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (start_legal_s) begin
            start_ok_s   = 1'b1;
            quiet_next_s = {QW{1'b0}};
            state_next_s = ST_WAIT_Q;
          end else begin
            start_bad_s  = 1'b1;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT_Q: begin
        if (abort) begin
          abort_s      = 1'b1;
          state_next_s = ST_IDLE;
        end else if (filter_busy) begin
          quiet_next_s = {QW{1'b0}};
        end else if (quiet_r == QUIET_LAST) begin
          quiet_next_s = {QW{1'b0}};
          state_next_s = ST_LOAD;
        end else begin
          quiet_next_s = quiet_r + QW'(1);
        end
      end
      ST_LOAD: begin
        if (abort) begin
          abort_s      = 1'b1;
          state_next_s = ST_IDLE;
        end else if (hs_s && last_word_s) begin
          settle_next_s = {SW{1'b0}};
          state_next_s  = ST_SETTLE;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          abort_s      = 1'b1;
          state_next_s = ST_IDLE;
        end else if (settle_r == SETTLE_LAST) begin
          state_next_s = ST_DONE;
        end else begin
          settle_next_s = settle_r + SW'(1);
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and its quiet/settle counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= ST_IDLE;
      quiet_r  <= {QW{1'b0}};
      settle_r <= {SW{1'b0}};
    end else begin
      state_r  <= state_next_s;
      quiet_r  <= quiet_next_s;
      settle_r <= settle_next_s;
    end
  end

  // Latched word count and the running write-address counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      num_r <= ZERO_L;
      cnt_r <= ZERO_L;
    end else if (start_ok_s) begin
      num_r <= num_words;
      cnt_r <= ZERO_L;
    end else if (hs_s) begin
      cnt_r <= cnt_r + ONE_L;
    end
  end

  // LUT write port: each accepted word is written one cycle after its handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      CLOAD <= 1'b0;
      CIN   <= {DATA_W{1'b0}};
      CADDR <= {ADDR_W{1'b0}};
    end else begin
      CLOAD <= hs_s;
      if (hs_s) begin
        CIN   <= s_if.s_data;
        CADDR <= cnt_r[ADDR_W-1:0];
      end
    end
  end

  // Host-side status is registered from the next state, so it lines up with the FSM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy        <= 1'b0;
      hold_filter <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      checksum    <= 24'd0;
    end else begin
      busy        <= (state_next_s != ST_IDLE);
      hold_filter <= (state_next_s != ST_IDLE);
      done        <= (state_next_s == ST_DONE);
      if (start_ok_s) begin
        error <= 1'b0;
      end else if (start_bad_s || abort_s) begin
        error <= 1'b1;
      end
      if (start_ok_s) begin
        checksum <= 24'd0;
      end else if (hs_s) begin
        checksum <= checksum + {{(24 - DATA_W){1'b0}}, s_if.s_data};
      end
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Self-checking bench for fir_coef_loader: table-driven load scenarios with a
// cycle model and a write scoreboard, plus hand-written abort and reset sequences.
module tb_fir_coef_loader;
  localparam int DATA_W = 19;
  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              filter_busy = 1'b0;
  logic [ADDR_W:0]   num_words = '0;
  logic [DATA_W-1:0] CIN;
  logic [ADDR_W-1:0] CADDR;
  logic              CLOAD, hold_filter, busy, done, error;
  logic [23:0]       checksum;

  fir_coef_loader_if #(.DATA_W(DATA_W)) s_if ();

  fir_coef_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(2048), .QUIET_CYCLES(4), .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort), .num_words(num_words),
    .s_if(s_if), .filter_busy(filter_busy), .CIN(CIN), .CADDR(CADDR), .CLOAD(CLOAD),
    .hold_filter(hold_filter), .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W:0]             nw;
    logic [15:0]                 vpat;
    logic [3:0][DATA_W-1:0]      w;
    int                          busy_mode;
    int                          delay;
    logic                        legal;
    logic [23:0]                 ck;
    int                          writes;
  } vec_t;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  vec_t vecs[7];
  wr_t  sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cload_seen = 0;
  logic prev_hs = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the LUT write port against the handshake of the previous cycle and the scoreboard.
  task automatic monitor();
    wr_t e;
    chk("cload_timing", 32'(CLOAD), 32'(prev_hs));
    if (CLOAD) begin
      cload_seen++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL cload_unexpected actual=CLOAD@%h expected=no_write", CADDR);
      end else begin
        e = sbq.pop_front();
        chk("cin", 32'(CIN), 32'(e.d));
        chk("caddr", 32'(CADDR), 32'(e.a));
      end
    end
  endtask

  function automatic logic busy_at(input int mode, input int k);
    if (mode == 1) return (k < 10) || (k == 13);
    return 1'b0;
  endfunction

  function automatic vec_t mk(input logic [ADDR_W:0] nw, input logic [15:0] vpat,
                              input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                              input logic [DATA_W-1:0] w2, input logic [DATA_W-1:0] w3,
                              input int bm, input int dly, input logic legal,
                              input logic [23:0] ck, input int writes);
    vec_t v;
    v.nw = nw; v.vpat = vpat; v.w = {w3, w2, w1, w0};
    v.busy_mode = bm; v.delay = dly; v.legal = legal; v.ck = ck; v.writes = writes;
    return v;
  endfunction

  // Applies one table row: start, then a cycle model of ready/busy/done/error per interval.
  task automatic run_vec(input int idx, input vec_t v);
    int   hcount = 0;
    int   last_k = -1;
    int   done_seen = 0;
    int   n = int'(v.nw);
    logic m_ready, m_busy, m_done, sv, hs;
    sbq.delete();
    prev_hs = 1'b0;
    cload_seen = 0;
    num_words = v.nw;
    start = 1'b1;
    s_if.s_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < n + 30; k++) begin
      monitor();
      m_ready = v.legal && (k >= v.delay) && (hcount < n);
      m_busy  = v.legal && ((last_k < 0) || (k <= last_k + 3));
      m_done  = v.legal && (last_k >= 0) && (k == last_k + 3);
      chk($sformatf("v%0d_s_ready", idx), 32'(s_if.s_ready), 32'(m_ready));
      chk($sformatf("v%0d_busy", idx), 32'(busy), 32'(m_busy));
      chk($sformatf("v%0d_hold", idx), 32'(hold_filter), 32'(m_busy));
      chk($sformatf("v%0d_done", idx), 32'(done), 32'(m_done));
      chk($sformatf("v%0d_error", idx), 32'(error), 32'(!v.legal));
      if (done) done_seen++;
      filter_busy = busy_at(v.busy_mode, k);
      if (k >= v.delay && hcount < n) sv = ((k - v.delay) < 16) ? v.vpat[k - v.delay] : 1'b1;
      else sv = 1'b0;
      s_if.s_valid = sv;
      s_if.s_data  = (hcount < n) ? v.w[hcount & 3] : '0;
      hs = sv && m_ready;
      if (hs) begin
        sbq.push_back('{a: ADDR_W'(hcount), d: v.w[hcount & 3]});
        hcount++;
        if (hcount == n) last_k = k;
      end
      prev_hs = hs;
      tick();
    end
    s_if.s_valid = 1'b0;
    filter_busy = 1'b0;
    chk($sformatf("v%0d_checksum", idx), 32'(checksum), 32'(v.ck));
    chk($sformatf("v%0d_writes", idx), 32'(cload_seen), 32'(v.writes));
    chk($sformatf("v%0d_done_count", idx), 32'(done_seen), 32'(v.legal ? 1 : 0));
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_cin"}, 32'(CIN), 32'h0);
    chk({nm, "_caddr"}, 32'(CADDR), 32'h0);
    chk({nm, "_cload"}, 32'(CLOAD), 32'h0);
    chk({nm, "_hold"}, 32'(hold_filter), 32'h0);
    chk({nm, "_busy"}, 32'(busy), 32'h0);
    chk({nm, "_done"}, 32'(done), 32'h0);
    chk({nm, "_error"}, 32'(error), 32'h0);
    chk({nm, "_checksum"}, 32'(checksum), 32'h0);
    chk({nm, "_s_ready"}, 32'(s_if.s_ready), 32'h0);
  endtask

  initial begin
    logic hs;
    int   hcount;
    vecs[0] = mk(12'd4, 16'hFFFF, 19'h00001, 19'h00002, 19'h7FFFF, 19'h40000, 0, 4, 1'b1, 24'h0C0002, 4);
    vecs[1] = mk(12'd3, 16'h0029, 19'h12345, 19'h00FFF, 19'h7FFFF, 19'h00000, 0, 4, 1'b1, 24'h093343, 3);
    vecs[2] = mk(12'd2, 16'hFFFF, 19'h00010, 19'h00020, 19'h00000, 19'h00000, 1, 18, 1'b1, 24'h000030, 2);
    vecs[3] = mk(12'd0, 16'hFFFF, 19'h00000, 19'h00000, 19'h00000, 19'h00000, 0, 99, 1'b0, 24'h000030, 0);
    vecs[4] = mk(12'd2049, 16'hFFFF, 19'h00000, 19'h00000, 19'h00000, 19'h00000, 0, 99, 1'b0, 24'h000030, 0);
    vecs[5] = mk(12'd1, 16'hFFFF, 19'h7FFFF, 19'h00000, 19'h00000, 19'h00000, 0, 4, 1'b1, 24'h07FFFF, 1);
    vecs[6] = mk(12'd2048, 16'hFFFF, 19'h00001, 19'h00002, 19'h00003, 19'h00004, 0, 4, 1'b1, 24'h001400, 2048);

    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Abort in the same cycle as the third handshake of an 8-word load.
    sbq.delete();
    prev_hs = 1'b0;
    cload_seen = 0;
    hcount = 0;
    num_words = 12'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      monitor();
      abort = (k == 6);
      s_if.s_valid = (k >= 4) && (k <= 6);
      s_if.s_data  = 19'h00100 + 19'(hcount);
      #1;
      chk("abort_s_ready", 32'(s_if.s_ready), 32'((k == 4) || (k == 5)));
      chk("abort_busy", 32'(busy), 32'(k <= 6));
      chk("abort_hold", 32'(hold_filter), 32'(k <= 6));
      chk("abort_error", 32'(error), 32'(k >= 7));
      chk("abort_done", 32'(done), 32'h0);
      hs = s_if.s_valid && ((k == 4) || (k == 5));
      if (hs) begin
        sbq.push_back('{a: ADDR_W'(hcount), d: 19'h00100 + 19'(hcount)});
        hcount++;
      end
      prev_hs = hs;
      tick();
    end
    abort = 1'b0;
    s_if.s_valid = 1'b0;
    chk("abort_writes", 32'(cload_seen), 32'd2);

    // Asynchronous reset between clock edges while a write is on the LUT port.
    sbq.delete();
    prev_hs = 1'b0;
    num_words = 12'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_if.s_valid = (k == 4);
      s_if.s_data  = 19'h55555;
      tick();
    end
    chk("rst_pre_cload", 32'(CLOAD), 32'h1);
    chk("rst_pre_caddr", 32'(CADDR), 32'h0);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("async_rst");
    #1;
    resetn = 1'b1;
    s_if.s_valid = 1'b0;
    run_vec(7, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
